thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler.sv | 121 ++++++++++++
 tb/tb_thread_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// ============================================================================
// Module   : thread_scheduler
// Purpose  : Per-thread IDLE/READY/WAIT_FILL tracking with a registered
//            round-robin fetch grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module thread_scheduler #(
    parameter  int N_THREADS = 4,
    localparam int TW        = $clog2(N_THREADS),
    localparam int CW        = $clog2(N_THREADS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_THREADS-1:0] thread_enable,
    input  logic                 icache_miss,
    input  logic                 itlb_miss,
    input  logic [TW-1:0]        miss_thread,
    input  logic                 fill_done,
    input  logic [TW-1:0]        fill_thread,
    input  logic                 stall,
    output logic                 fetch_valid,
    output logic [TW-1:0]        fetch_thread,
    output logic [N_THREADS-1:0] thread_blocked,
    output logic [CW-1:0]        n_blocked
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READY     = 2'd1,
        ST_WAIT_FILL = 2'd2
    } state_t;

    state_t                state_q [N_THREADS];
    state_t                state_d [N_THREADS];
    logic                  fetch_valid_q;
    logic [TW-1:0]         fetch_thread_q;
    logic [TW-1:0]         last_grant_q;

    logic [N_THREADS-1:0]  miss_hit;
    logic [N_THREADS-1:0]  fill_hit;
    logic [N_THREADS-1:0]  eligible;
    logic                  grant_found;
    logic [TW-1:0]         grant_winner;
    int                    rr_idx;
    logic [CW-1:0]         blocked_cnt;

    // Per-thread next state; disable dominates, then the current state decides
    // whether a miss or a fill is the one that applies.
    always_comb begin
        for (int i = 0; i < N_THREADS; i++) begin
            miss_hit[i] = (icache_miss | itlb_miss) && (miss_thread == TW'(i));
            fill_hit[i] = fill_done && (fill_thread == TW'(i));
            eligible[i] = (state_q[i] == ST_READY) && thread_enable[i] && !miss_hit[i];
            state_d[i]  = state_q[i];
            if (!thread_enable[i]) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE:      state_d[i] = ST_READY;
                    ST_READY:     state_d[i] = miss_hit[i] ? ST_WAIT_FILL : ST_READY;
                    ST_WAIT_FILL: state_d[i] = fill_hit[i] ? ST_READY : ST_WAIT_FILL;
                    default:      state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Search starts one past the last winner and wraps; k = N_THREADS lands
    // back on the last winner, so it only repeats when it is the sole candidate.
    always_comb begin
        grant_found  = 1'b0;
        grant_winner = last_grant_q;
        rr_idx       = 0;
        for (int k = 1; k <= N_THREADS; k++) begin
            rr_idx = (int'(last_grant_q) + k) % N_THREADS;
            if (!grant_found && eligible[rr_idx]) begin
                grant_found  = 1'b1;
                grant_winner = TW'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                state_q[i] <= ST_IDLE;
            end
            fetch_valid_q  <= 1'b0;
            fetch_thread_q <= '0;
            last_grant_q   <= TW'(N_THREADS - 1);
        end else begin
            for (int i = 0; i < N_THREADS; i++) begin
                state_q[i] <= state_d[i];
            end
            if (!stall) begin
                fetch_valid_q <= grant_found;
                if (grant_found) begin
                    fetch_thread_q <= grant_winner;
                    last_grant_q   <= grant_winner;
                end
            end
        end
    end

    always_comb begin
        blocked_cnt = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            thread_blocked[i] = (state_q[i] == ST_WAIT_FILL);
            blocked_cnt       = blocked_cnt + CW'(thread_blocked[i]);
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign fetch_thread = fetch_thread_q;
    assign n_blocked    = blocked_cnt;

endmodule

`default_nettype wire

// File: tb/tb_thread_scheduler.sv
// ============================================================================
// Module   : tb_thread_scheduler
// Purpose  : Directed stimulus with a cycle-tagged scoreboard for thread_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_thread_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   en;
    logic         icm, itm, fd, stl;
    logic [1:0]   mt, ft;
    logic         fetch_valid;
    logic [1:0]   fetch_thread;
    logic [3:0]   thread_blocked;
    logic [2:0]   n_blocked;

    typedef struct {
        int         cyc;
        string      nm;
        logic       v;
        logic [1:0] th;
        logic       chk_th;
        logic [3:0] blk;
        logic [2:0] nb;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    thread_scheduler #(.N_THREADS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .thread_enable  (en),
        .icache_miss    (icm),
        .itlb_miss      (itm),
        .miss_thread    (mt),
        .fill_done      (fd),
        .fill_thread    (ft),
        .stall          (stl),
        .fetch_valid    (fetch_valid),
        .fetch_thread   (fetch_thread),
        .thread_blocked (thread_blocked),
        .n_blocked      (n_blocked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expectation for the outputs visible k edges from now.
    task automatic expect_out(input int k, input string nm, input logic v, input logic [1:0] th,
                              input logic chk, input logic [3:0] blk, input logic [2:0] nb);
        exp_t e;
        e.cyc = cyc + k; e.nm = nm; e.v = v; e.th = th; e.chk_th = chk; e.blk = blk; e.nb = nb;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (e.cyc < cyc) begin
                    bad++;
                    $display("FAIL %s stale expectation for cycle %0d seen at %0d", e.nm, e.cyc, cyc);
                end else if (fetch_valid !== e.v || (e.chk_th && fetch_thread !== e.th) ||
                             thread_blocked !== e.blk || n_blocked !== e.nb) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got v=%b th=%0d blk=%b nb=%0d want v=%b th=%0d blk=%b nb=%0d",
                             e.nm, cyc, fetch_valid, fetch_thread, thread_blocked, n_blocked,
                             e.v, e.th, e.blk, e.nb);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; en = 4'h0; icm = 0; itm = 0; fd = 0; stl = 0; mt = 0; ft = 0;
        tick(); tick();
        expect_out(0, "reset", 0, 0, 1, 4'b0000, 0);

        // Round robin from reset release
        en = 4'hF;
        tick(); rst = 1'b0;
        expect_out(1, "rr_idle", 0, 0, 1, 4'b0000, 0);
        expect_out(2, "rr0",     1, 0, 1, 4'b0000, 0);
        expect_out(3, "rr1",     1, 1, 1, 4'b0000, 0);
        expect_out(4, "rr2",     1, 2, 1, 4'b0000, 0);
        expect_out(5, "rr3",     1, 3, 1, 4'b0000, 0);
        expect_out(6, "rr_wrap", 1, 0, 1, 4'b0000, 0);
        repeat (6) tick();

        // icache miss on thread 1, then fill
        icm = 1; mt = 1;
        expect_out(1, "miss1_grant", 1, 2, 1, 4'b0010, 1);
        tick(); icm = 0;
        expect_out(1, "skip1_a", 1, 3, 1, 4'b0010, 1);
        expect_out(2, "skip1_b", 1, 0, 1, 4'b0010, 1);
        expect_out(3, "skip1_c", 1, 2, 1, 4'b0010, 1);
        repeat (3) tick();
        fd = 1; ft = 1;
        expect_out(1, "fill1_a",    1, 3, 1, 4'b0000, 0);
        expect_out(2, "fill1_b",    1, 0, 1, 4'b0000, 0);
        expect_out(3, "fill1_back", 1, 1, 1, 4'b0000, 0);
        tick(); fd = 0; tick(); tick();

        // itlb miss on thread 2, then miss+fill on thread 2 together
        itm = 1; mt = 2;
        expect_out(1, "tlb2_block", 1, 3, 1, 4'b0100, 1);
        tick(); fd = 1; ft = 2;
        expect_out(1, "tlb2_fill_same", 1, 0, 1, 4'b0000, 0);
        expect_out(2, "tlb2_r1",        1, 1, 1, 4'b0000, 0);
        expect_out(3, "tlb2_r2",        1, 2, 1, 4'b0000, 0);
        tick(); itm = 0; fd = 0; tick(); tick();

        // Stall holds the grant at 2 while thread 0 still takes a miss
        stl = 1; icm = 1; mt = 0;
        expect_out(1, "stall_a", 1, 2, 1, 4'b0001, 1);
        expect_out(2, "stall_b", 1, 2, 1, 4'b0001, 1);
        expect_out(3, "stall_c", 1, 2, 1, 4'b0001, 1);
        tick(); icm = 0; tick(); tick();
        stl = 0;
        expect_out(1, "stall_release", 1, 3, 1, 4'b0001, 1);
        tick();

        // Drive every thread into WAIT_FILL, then release one
        icm = 1; mt = 1;
        expect_out(1, "allwait_a", 1, 2, 1, 4'b0011, 2);
        tick(); mt = 2;
        expect_out(1, "allwait_b", 1, 3, 1, 4'b0111, 3);
        tick(); mt = 3;
        expect_out(1, "allwait_none", 0, 3, 1, 4'b1111, 4);
        tick(); icm = 0;
        expect_out(1, "allwait_hold", 0, 3, 1, 4'b1111, 4);
        tick(); fd = 1; ft = 1;
        expect_out(1, "fill_edge1", 0, 3, 1, 4'b1101, 3);
        expect_out(2, "fill_edge2", 1, 1, 1, 4'b1101, 3);
        tick(); fd = 0; tick();
        tick();

        // Asynchronous reset between edges with thread 0 waiting
        expect_out(0, "async_rst", 0, 0, 1, 4'b0000, 0);
        fd = 1; ft = 0;
        #1 rst = 1'b1;
        #5 rst = 1'b0;
        expect_out(1, "post_rst_idle",  0, 0, 1, 4'b0000, 0);
        expect_out(2, "post_rst_first", 1, 0, 1, 4'b0000, 0);
        expect_out(3, "post_rst_next",  1, 1, 1, 4'b0000, 0);
        tick(); tick(); fd = 0; tick();

        // Disabling a waiting thread drops it and discards its fill
        icm = 1; mt = 3;
        expect_out(1, "dis_block3", 1, 2, 1, 4'b1000, 1);
        tick(); icm = 0; en = 4'b0111;
        expect_out(1, "dis_drop3", 1, 0, 1, 4'b0000, 0);
        tick(); fd = 1; ft = 3;
        expect_out(1, "dis_fill_ign", 1, 1, 1, 4'b0000, 0);
        tick(); fd = 0;
        expect_out(1, "dis_rr_a", 1, 2, 1, 4'b0000, 0);
        expect_out(2, "dis_rr_b", 1, 0, 1, 4'b0000, 0);
        repeat (4) tick();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover %0d expectations never checked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
